// File: rtl/dfi_cmd_sequencer.sv
// DFI command sequencer: runs the DDR power-up/mode-register init sequence on
// p0, then passes host commands onto the selected phase and inserts periodic
// PRECHARGE-ALL + AUTO-REFRESH pairs. All DFI outputs are registered.
module dfi_cmd_sequencer #(
    parameter int NUM_AD  = 13,
    parameter int NUM_BA  = 2,
    parameter int TINIT   = 20000,
    parameter int TRP     = 2,
    parameter int TMRD    = 2,
    parameter int TRFC    = 10,
    parameter int TDLL    = 200,
    parameter int TREFI   = 780,
    parameter int TGUARD  = 4,
    parameter logic [NUM_AD-1:0] MR_VAL  = NUM_AD'(13'h0022),
    parameter logic [NUM_AD-1:0] EMR_VAL = NUM_AD'(13'h0000)
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_phase,
    input  logic              cmd_ras_n,
    input  logic              cmd_cas_n,
    input  logic              cmd_we_n,
    input  logic [NUM_AD-1:0] cmd_a,
    input  logic [NUM_BA-1:0] cmd_ba,
    output logic              init_done,
    output logic [NUM_AD-1:0] dfi_address_p0,
    output logic [NUM_AD-1:0] dfi_address_p1,
    output logic [NUM_BA-1:0] dfi_bank_p0,
    output logic [NUM_BA-1:0] dfi_bank_p1,
    output logic              dfi_cs_n_p0,
    output logic              dfi_cs_n_p1,
    output logic              dfi_cke_p0,
    output logic              dfi_cke_p1,
    output logic              dfi_ras_n_p0,
    output logic              dfi_ras_n_p1,
    output logic              dfi_cas_n_p0,
    output logic              dfi_cas_n_p1,
    output logic              dfi_we_n_p0,
    output logic              dfi_we_n_p1
);

    // One phase word is {cs_n, ras_n, cas_n, we_n, bank, address}
    localparam int PW    = 4 + NUM_BA + NUM_AD;
    // The sum bounds every individual wait, so the shared counter always fits
    localparam int CNT_W = $clog2(TINIT + TDLL + TRFC + TRP + TMRD + TGUARD + 1);
    localparam int REF_W = $clog2(TREFI + 1);

    localparam logic [3:0] ENC_NOP  = 4'b0111;
    localparam logic [3:0] ENC_PRE  = 4'b0010;
    localparam logic [3:0] ENC_AREF = 4'b0001;
    localparam logic [3:0] ENC_LMR  = 4'b0000;
    localparam logic [3:0] ENC_RST  = 4'b1111;

    localparam logic [NUM_AD-1:0] A_ALLBANK = NUM_AD'(1024); // A10
    localparam logic [NUM_AD-1:0] A_DLLRST  = NUM_AD'(256);  // A8
    localparam logic [NUM_BA-1:0] BA_ZERO   = '0;
    localparam logic [NUM_AD-1:0] A_ZERO    = '0;

    localparam logic [PW-1:0] W_NOP   = {ENC_NOP, BA_ZERO, A_ZERO};
    localparam logic [PW-1:0] W_RST   = {ENC_RST, BA_ZERO, A_ZERO};
    localparam logic [PW-1:0] W_PRE   = {ENC_PRE, BA_ZERO, A_ALLBANK};
    localparam logic [PW-1:0] W_AREF  = {ENC_AREF, BA_ZERO, A_ZERO};
    localparam logic [PW-1:0] W_EMR   = {ENC_LMR, NUM_BA'(1), EMR_VAL};
    localparam logic [PW-1:0] W_MRDLL = {ENC_LMR, BA_ZERO, MR_VAL | A_DLLRST};
    localparam logic [PW-1:0] W_MR    = {ENC_LMR, BA_ZERO, MR_VAL & ~A_DLLRST};

    // Command states issue their command in the entry cycle, then idle on NOP
    // until the shared counter has run down.
    typedef enum logic [3:0] {
        S_WAIT_INIT, S_CKE_ON, S_PRE1, S_EMR, S_MRDLL, S_PRE2, S_REF1, S_REF2,
        S_MR, S_DLL, S_IDLE, S_GUARD, S_REF_PRE, S_REF_AR
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [REF_W-1:0]  ref_cnt_q, ref_cnt_d;
    logic              ref_pending_q, ref_pending_d;
    logic              init_done_q, init_done_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic              cke_q, cke_d;
    logic [PW-1:0]     ph0_q, ph0_d;
    logic [PW-1:0]     ph1_q, ph1_d;
    logic              cnt_zero;
    logic              ref_load;
    logic              ref_clear;
    logic [PW-1:0]     host_word;

    assign cnt_zero  = (cnt_q == '0);
    assign host_word = {1'b0, cmd_ras_n, cmd_cas_n, cmd_we_n, cmd_ba, cmd_a};

    // Next-state, wait counter, refresh bookkeeping and next-cycle DFI words
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_zero ? cnt_q : cnt_q - 1'b1;
        ph0_d         = W_NOP;
        ph1_d         = W_NOP;
        ref_load      = 1'b0;
        ref_clear     = 1'b0;
        ref_cnt_d     = ref_cnt_q;
        ref_pending_d = ref_pending_q;

        case (state_q)
            S_WAIT_INIT: if (cnt_zero) state_d = S_CKE_ON;
            S_CKE_ON: begin
                state_d = S_PRE1;  cnt_d = CNT_W'(TRP);  ph0_d = W_PRE;
            end
            S_PRE1: if (cnt_zero) begin
                state_d = S_EMR;   cnt_d = CNT_W'(TMRD); ph0_d = W_EMR;
            end
            S_EMR: if (cnt_zero) begin
                state_d = S_MRDLL; cnt_d = CNT_W'(TMRD); ph0_d = W_MRDLL;
            end
            S_MRDLL: if (cnt_zero) begin
                state_d = S_PRE2;  cnt_d = CNT_W'(TRP);  ph0_d = W_PRE;
            end
            S_PRE2: if (cnt_zero) begin
                state_d = S_REF1;  cnt_d = CNT_W'(TRFC); ph0_d = W_AREF;
            end
            S_REF1: if (cnt_zero) begin
                state_d = S_REF2;  cnt_d = CNT_W'(TRFC); ph0_d = W_AREF;
            end
            S_REF2: if (cnt_zero) begin
                state_d = S_MR;    cnt_d = CNT_W'(TMRD); ph0_d = W_MR;
            end
            S_MR: if (cnt_zero) begin
                state_d = S_DLL;   cnt_d = CNT_W'(TDLL - 1);
            end
            S_DLL: if (cnt_zero) begin
                state_d = S_IDLE;  ref_load = 1'b1;
            end
            S_IDLE: begin
                // cmd_ready_q already excludes a pending refresh
                if (ref_pending_q) begin
                    state_d = S_GUARD; cnt_d = CNT_W'(TGUARD - 1);
                end else if (cmd_valid && cmd_ready_q) begin
                    if (cmd_phase) ph1_d = host_word;
                    else           ph0_d = host_word;
                end
            end
            S_GUARD: if (cnt_zero) begin
                state_d = S_REF_PRE; cnt_d = CNT_W'(TRP); ph0_d = W_PRE;
            end
            S_REF_PRE: if (cnt_zero) begin
                state_d = S_REF_AR;  cnt_d = CNT_W'(TRFC); ph0_d = W_AREF;
                ref_clear = 1'b1;
            end
            S_REF_AR: if (cnt_zero) state_d = S_IDLE;
            default: begin
                state_d = S_WAIT_INIT; cnt_d = CNT_W'(TINIT - 1);
            end
        endcase

        // A fresh expiry wins over the clear so no interval is lost
        if (ref_clear) ref_pending_d = 1'b0;
        if (ref_load) begin
            ref_cnt_d = REF_W'(TREFI - 1);
        end else if (init_done_q) begin
            if (ref_cnt_q == '0) begin
                ref_cnt_d     = REF_W'(TREFI - 1);
                ref_pending_d = 1'b1;
            end else begin
                ref_cnt_d = ref_cnt_q - 1'b1;
            end
        end

        cke_d       = (state_d != S_WAIT_INIT);
        init_done_d = init_done_q || (state_d == S_IDLE);
        cmd_ready_d = (state_d == S_IDLE) && !ref_pending_d;
    end

    // State and output registers; reset drops every DFI line immediately
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q       <= S_WAIT_INIT;
            cnt_q         <= CNT_W'(TINIT - 1);
            ref_cnt_q     <= '0;
            ref_pending_q <= 1'b0;
            init_done_q   <= 1'b0;
            cmd_ready_q   <= 1'b0;
            cke_q         <= 1'b0;
            ph0_q         <= W_RST;
            ph1_q         <= W_RST;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            ref_cnt_q     <= ref_cnt_d;
            ref_pending_q <= ref_pending_d;
            init_done_q   <= init_done_d;
            cmd_ready_q   <= cmd_ready_d;
            cke_q         <= cke_d;
            ph0_q         <= ph0_d;
            ph1_q         <= ph1_d;
        end
    end

    assign cmd_ready  = cmd_ready_q;
    assign init_done  = init_done_q;
    assign dfi_cke_p0 = cke_q;
    assign dfi_cke_p1 = cke_q;
    assign {dfi_cs_n_p0, dfi_ras_n_p0, dfi_cas_n_p0, dfi_we_n_p0,
            dfi_bank_p0, dfi_address_p0} = ph0_q;
    assign {dfi_cs_n_p1, dfi_ras_n_p1, dfi_cas_n_p1, dfi_we_n_p1,
            dfi_bank_p1, dfi_address_p1} = ph1_q;

endmodule

// File: tb/tb_dfi_cmd_sequencer.sv
// Bench for dfi_cmd_sequencer: init sequence from a command table, randomized
// host traffic against a timeline model of refresh windows, async reset abort.
module tb_dfi_cmd_sequencer;

    localparam int NUM_AD = 13;
    localparam int NUM_BA = 2;
    localparam int TINIT  = 10;
    localparam int TRP    = 2;
    localparam int TMRD   = 2;
    localparam int TRFC   = 8;
    localparam int TDLL   = 20;
    localparam int TREFI  = 60;
    localparam int TGUARD = 3;
    localparam logic [12:0] MR_VAL  = 13'h0022;
    localparam logic [12:0] EMR_VAL = 13'h0000;

    localparam int PW    = 4 + NUM_BA + NUM_AD;
    localparam int OBS_W = 4 + 2 * PW;
    // Refresh window, counted from the expiry cycle: one IDLE cycle, the guard,
    // PRE + TRP, AREF + TRFC
    localparam int WIN      = 1 + TGUARD + 1 + TRP + 1 + TRFC;
    localparam int OFF_PRE  = TGUARD + 2;
    localparam int OFF_AREF = OFF_PRE + TRP + 1;

    localparam logic [PW-1:0] W_NOP  = {4'b0111, 2'b00, 13'h0000};
    localparam logic [PW-1:0] W_RST  = {4'b1111, 2'b00, 13'h0000};
    localparam logic [PW-1:0] W_PRE  = {4'b0010, 2'b00, 13'h0400};
    localparam logic [PW-1:0] W_AREF = {4'b0001, 2'b00, 13'h0000};
    localparam logic [OBS_W-1:0] RST_OBS = {4'b0000, W_RST, W_RST};

    logic              clk;
    logic              sys_rst_n;
    logic              cmd_valid, cmd_ready, cmd_phase;
    logic              cmd_ras_n, cmd_cas_n, cmd_we_n;
    logic [NUM_AD-1:0] cmd_a;
    logic [NUM_BA-1:0] cmd_ba;
    logic              init_done;
    logic [NUM_AD-1:0] dfi_address_p0, dfi_address_p1;
    logic [NUM_BA-1:0] dfi_bank_p0, dfi_bank_p1;
    logic dfi_cs_n_p0, dfi_cs_n_p1, dfi_cke_p0, dfi_cke_p1;
    logic dfi_ras_n_p0, dfi_ras_n_p1, dfi_cas_n_p0, dfi_cas_n_p1;
    logic dfi_we_n_p0, dfi_we_n_p1;

    dfi_cmd_sequencer #(
        .NUM_AD(NUM_AD), .NUM_BA(NUM_BA), .TINIT(TINIT), .TRP(TRP),
        .TMRD(TMRD), .TRFC(TRFC), .TDLL(TDLL), .TREFI(TREFI),
        .TGUARD(TGUARD), .MR_VAL(MR_VAL), .EMR_VAL(EMR_VAL)
    ) dut (
        .sys_clk(clk), .sys_rst_n(sys_rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_phase(cmd_phase),
        .cmd_ras_n(cmd_ras_n), .cmd_cas_n(cmd_cas_n), .cmd_we_n(cmd_we_n),
        .cmd_a(cmd_a), .cmd_ba(cmd_ba), .init_done(init_done),
        .dfi_address_p0(dfi_address_p0), .dfi_address_p1(dfi_address_p1),
        .dfi_bank_p0(dfi_bank_p0), .dfi_bank_p1(dfi_bank_p1),
        .dfi_cs_n_p0(dfi_cs_n_p0), .dfi_cs_n_p1(dfi_cs_n_p1),
        .dfi_cke_p0(dfi_cke_p0), .dfi_cke_p1(dfi_cke_p1),
        .dfi_ras_n_p0(dfi_ras_n_p0), .dfi_ras_n_p1(dfi_ras_n_p1),
        .dfi_cas_n_p0(dfi_cas_n_p0), .dfi_cas_n_p1(dfi_cas_n_p1),
        .dfi_we_n_p0(dfi_we_n_p0), .dfi_we_n_p1(dfi_we_n_p1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Everything observable in one vector: {cke0, cke1, init_done, ready, p0, p1}
    logic [OBS_W-1:0] obs;
    assign obs = {dfi_cke_p0, dfi_cke_p1, init_done, cmd_ready,
                  dfi_cs_n_p0, dfi_ras_n_p0, dfi_cas_n_p0, dfi_we_n_p0,
                  dfi_bank_p0, dfi_address_p0,
                  dfi_cs_n_p1, dfi_ras_n_p1, dfi_cas_n_p1, dfi_we_n_p1,
                  dfi_bank_p1, dfi_address_p1};

    typedef struct {
        string             name;
        logic [3:0]        enc;
        logic [NUM_BA-1:0] ba;
        logic [NUM_AD-1:0] a;
        int                gap;
    } step_t;

    step_t            init_tab [7];
    logic [OBS_W-1:0] init_exp [$];
    int               t0;
    int               n_cmp = 0;
    int               n_bad = 0;

    logic             prev_hs;
    logic             prev_ph;
    logic [PW-1:0]    prev_w;

    task automatic check(input string name, input int t,
                         input logic [OBS_W-1:0] got, input logic [OBS_W-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s t=%0d got=%h expected=%h", name, t, got, exp);
        end
    endtask

    task automatic build_init();
        init_exp.delete();
        init_exp.push_back({4'b0000, W_RST, W_RST});
        for (int i = 1; i < TINIT; i++) init_exp.push_back({4'b0000, W_NOP, W_NOP});
        init_exp.push_back({4'b1100, W_NOP, W_NOP});
        foreach (init_tab[s]) begin
            init_exp.push_back({4'b1100, init_tab[s].enc, init_tab[s].ba, init_tab[s].a, W_NOP});
            for (int g = 0; g < init_tab[s].gap; g++) init_exp.push_back({4'b1100, W_NOP, W_NOP});
        end
        for (int i = 0; i < TDLL; i++) init_exp.push_back({4'b1100, W_NOP, W_NOP});
        t0 = init_exp.size();
    endtask

    task automatic drive_inputs(input logic v, input logic ph);
        cmd_valid = v;
        cmd_phase = ph;
        cmd_ras_n = 1'($urandom);
        cmd_cas_n = 1'($urandom);
        cmd_we_n  = 1'($urandom);
        cmd_a     = 13'($urandom);
        cmd_ba    = 2'($urandom);
    endtask

    // Caller releases reset on a negedge; t=0 is sampled right there
    task automatic run_init();
        for (int t = 0; t < t0; t++) begin
            if (t > 0) @(negedge clk);
            check(init_tab[0].name == "" ? "init" : "init_seq", t, obs, init_exp[t]);
            drive_inputs(1'($urandom), 1'($urandom));
        end
    endtask

    // i counts cycles since IDLE entry; expiry k happens at i = k*TREFI - 1
    task automatic run_idle(input int first, input int last, input bit stop_mid);
        for (int i = first; i < last; i++) begin
            int rel, k, off;
            logic win, rdy, v, ph;
            logic [PW-1:0] w0, w1;
            @(negedge clk);
            rel = i + 1;
            k   = rel / TREFI;
            off = rel % TREFI;
            win = (k >= 1) && (off >= 1) && (off <= WIN);
            rdy = !win;
            w0 = W_NOP;
            w1 = W_NOP;
            if (prev_hs) begin
                if (prev_ph) w1 = prev_w;
                else         w0 = prev_w;
            end else if (win && off == OFF_PRE) begin
                w0 = W_PRE;
            end else if (win && off == OFF_AREF) begin
                w0 = W_AREF;
            end
            check("idle", t0 + i, obs, {3'b111, rdy, w0, w1});
            if (stop_mid && win && off == OFF_AREF + 2) return;
            v  = (i < 80) ? 1'b1 : 1'($urandom_range(0, 3) != 0);
            if (k >= 1 && off == 0) v = 1'b1;          // collide with expiry
            ph = (i == 0) ? 1'b0 : (i == 1) ? 1'b1 : 1'($urandom);
            drive_inputs(v, ph);
            prev_hs = v && rdy;
            prev_ph = ph;
            prev_w  = {1'b0, cmd_ras_n, cmd_cas_n, cmd_we_n, cmd_ba, cmd_a};
        end
    endtask

    initial begin
        init_tab[0] = '{"PRE1",  4'b0010, 2'd0, 13'h0400,                TRP};
        init_tab[1] = '{"EMR",   4'b0000, 2'd1, EMR_VAL,                 TMRD};
        init_tab[2] = '{"MRDLL", 4'b0000, 2'd0, MR_VAL | 13'h0100,       TMRD};
        init_tab[3] = '{"PRE2",  4'b0010, 2'd0, 13'h0400,                TRP};
        init_tab[4] = '{"REF1",  4'b0001, 2'd0, 13'h0000,                TRFC};
        init_tab[5] = '{"REF2",  4'b0001, 2'd0, 13'h0000,                TRFC};
        init_tab[6] = '{"MR",    4'b0000, 2'd0, MR_VAL & ~13'h0100,      TMRD};
        build_init();

        sys_rst_n = 1'b0;
        prev_hs   = 1'b0;
        prev_ph   = 1'b0;
        prev_w    = W_NOP;
        drive_inputs(1'b0, 1'b0);
        repeat (3) @(negedge clk);
        check("reset_state", 0, obs, RST_OBS);
        $display("reset state checked, init sequence of %0d cycles expected", t0);

        sys_rst_n = 1'b1;
        run_init();
        $display("init sequence compared, entering traffic");
        run_idle(0, 200, 1'b0);
        $display("traffic with three refresh windows compared");
        run_idle(200, 320, 1'b1);

        // Abort inside the TRFC wait: outputs must fall before the next edge
        #2 sys_rst_n = 1'b0;
        #1 check("async_reset", -1, obs, RST_OBS);
        repeat (2) @(negedge clk);
        check("reset_hold", -1, obs, RST_OBS);
        sys_rst_n = 1'b1;
        prev_hs = 1'b0;
        run_init();
        run_idle(0, 80, 1'b0);
        $display("init replay after mid-refresh reset compared");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
